imem_loader: RTL and testbench

Boot-time writer for the instruction memory. It receives a framed byte stream over a valid/ready handshake, assembles big-endian 32-bit words and issues one write per word into `i_mem`. While loading, it holds the `mips` core in reset so the core only fetches a complete, checksum-verified program. It sits beside `i_mem` as the write side of the port that the core's fetch path reads.

---
 rtl/mips_pkg.sv | 17 +
 rtl/word_assembler.sv | 46 ++++
 rtl/imem_loader.sv | 151 +++++++++++++++
 tb/tb_imem_loader.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package mips_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LEN_HI,
      LEN_LO,
      DATA,
      CHECK,
      DONE,
      ERR
   } loader_state_t;

   localparam int unsigned LOADER_BYTES_PER_WORD = 4;
   localparam int unsigned LOADER_LEN_BYTES      = 2;

endpackage

// File: rtl/word_assembler.sv
// Packs a byte stream MSB-first into 32-bit words and flags the last byte of each word.
module word_assembler
   import mips_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        clear_i,
   input  logic        valid_i,
   input  logic [7:0]  data_i,
   output logic [31:0] word_o,
   output logic        last_o
);

   localparam int unsigned CntW = $clog2(LOADER_BYTES_PER_WORD);
   localparam logic [CntW-1:0] LastCnt = CntW'(LOADER_BYTES_PER_WORD - 1);

   logic [CntW-1:0] cnt_q, cnt_d;
   logic [23:0]     shift_q, shift_d;

   // Word as it will be once the byte currently on data_i is accepted.
   assign word_o = {shift_q, data_i};
   assign last_o = (cnt_q == LastCnt);

   always_comb begin
      cnt_d   = cnt_q;
      shift_d = shift_q;
      if (clear_i) begin
         cnt_d   = '0;
         shift_d = '0;
      end else if (valid_i) begin
         cnt_d   = cnt_q + CntW'(1);
         shift_d = word_o[23:0];
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q   <= '0;
         shift_q <= '0;
      end else begin
         cnt_q   <= cnt_d;
         shift_q <= shift_d;
      end
   end

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction-memory writer: framed byte stream in, one word write per 4 bytes out,
// core held in reset until the whole program has loaded and its XOR checksum matched.
module imem_loader
   import mips_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int unsigned MAX_WORDS = 256
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_ready,
   output logic        wr_en,
   output logic [31:0] wr_addr,
   output logic [31:0] wr_data,
   output logic        core_hold,
   output logic        done,
   output logic        error
);

   localparam int unsigned LenW = 8 * LOADER_LEN_BYTES;
   localparam logic [LenW-1:0] MaxLen = LenW'(MAX_WORDS);

   loader_state_t   state_q, state_d;
   logic [LenW-1:0] len_q, len_d;
   logic [LenW-1:0] word_cnt_q, word_cnt_d;
   logic [7:0]      xor_q, xor_d;
   logic [31:0]     addr_q, addr_d;
   logic            wr_en_q, wr_en_d;
   logic [31:0]     wr_addr_q, wr_addr_d;
   logic [31:0]     wr_data_q, wr_data_d;

   logic            xfer;
   logic            start_ok;
   logic            data_xfer;
   logic            byte_last;
   logic [31:0]     word_next;
   logic [LenW-1:0] len_rx;

   assign rx_ready  = (state_q == LEN_HI) || (state_q == LEN_LO) ||
                      (state_q == DATA)   || (state_q == CHECK);
   assign xfer      = rx_valid && rx_ready;
   assign data_xfer = xfer && (state_q == DATA);
   // start only matters where no byte can transfer, so it never races a transfer.
   assign start_ok  = start && ((state_q == IDLE) || (state_q == DONE) || (state_q == ERR));
   assign len_rx    = {len_q[LenW-1:8], rx_data};

   word_assembler u_word_assembler (
      .clk_i   (clock),
      .rst_ni  (reset),
      .clear_i (start_ok),
      .valid_i (data_xfer),
      .data_i  (rx_data),
      .word_o  (word_next),
      .last_o  (byte_last)
   );

   always_comb begin
      state_d    = state_q;
      len_d      = len_q;
      word_cnt_d = word_cnt_q;
      xor_d      = xor_q;
      addr_d     = addr_q;
      wr_en_d    = 1'b0;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;

      unique case (state_q)
         IDLE, DONE, ERR: begin
            if (start_ok) begin
               state_d    = LEN_HI;
               len_d      = '0;
               word_cnt_d = '0;
               xor_d      = '0;
               addr_d     = BASE_ADDR;
            end
         end
         LEN_HI: begin
            if (xfer) begin
               len_d   = {rx_data, len_q[7:0]};
               state_d = LEN_LO;
            end
         end
         LEN_LO: begin
            if (xfer) begin
               len_d = len_rx;
               if (len_rx == '0) begin
                  state_d = CHECK;
               end else if (len_rx > MaxLen) begin
                  state_d = ERR;
               end else begin
                  state_d = DATA;
               end
            end
         end
         DATA: begin
            if (xfer) begin
               xor_d = xor_q ^ rx_data;
               if (byte_last) begin
                  wr_en_d    = 1'b1;
                  wr_addr_d  = addr_q;
                  wr_data_d  = word_next;
                  addr_d     = addr_q + 32'(LOADER_BYTES_PER_WORD);
                  word_cnt_d = word_cnt_q + LenW'(1);
                  if (word_cnt_q == len_q - LenW'(1)) begin
                     state_d = CHECK;
                  end
               end
            end
         end
         CHECK: begin
            if (xfer) begin
               state_d = (rx_data == xor_q) ? DONE : ERR;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         len_q      <= '0;
         word_cnt_q <= '0;
         xor_q      <= '0;
         addr_q     <= BASE_ADDR;
         wr_en_q    <= 1'b0;
         wr_addr_q  <= BASE_ADDR;
         wr_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         len_q      <= len_d;
         word_cnt_q <= word_cnt_d;
         xor_q      <= xor_d;
         addr_q     <= addr_d;
         wr_en_q    <= wr_en_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
      end
   end

   assign wr_en     = wr_en_q;
   assign wr_addr   = wr_addr_q;
   assign wr_data   = wr_data_q;
   assign core_hold = (state_q != DONE);
   assign done      = (state_q == DONE);
   assign error     = (state_q == ERR);

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: two instances (base 0 and base 0xFFFFFFFC), write scoreboard.
module tb_imem_loader;

   localparam logic [31:0] Base0 = 32'h0000_0000;
   localparam logic [31:0] Base1 = 32'hFFFF_FFFC;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start    [2];
   logic        rx_valid [2];
   logic [7:0]  rx_data  [2];
   logic        rx_ready [2];
   logic        wr_en    [2];
   logic [31:0] wr_addr  [2];
   logic [31:0] wr_data  [2];
   logic        core_hold[2];
   logic        done     [2];
   logic        error    [2];

   int          total = 0;
   int          bad   = 0;
   int          cyc   = 0;
   int          t0;
   logic [7:0]  chk;
   logic [64:0] exp_q[$];
   logic [64:0] mon_e;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   imem_loader #(.BASE_ADDR(Base0), .MAX_WORDS(256)) dut0 (
      .clock     (clk),
      .reset     (rst_n),
      .start     (start[0]),
      .rx_data   (rx_data[0]),
      .rx_valid  (rx_valid[0]),
      .rx_ready  (rx_ready[0]),
      .wr_en     (wr_en[0]),
      .wr_addr   (wr_addr[0]),
      .wr_data   (wr_data[0]),
      .core_hold (core_hold[0]),
      .done      (done[0]),
      .error     (error[0])
   );

   imem_loader #(.BASE_ADDR(Base1), .MAX_WORDS(256)) dut1 (
      .clock     (clk),
      .reset     (rst_n),
      .start     (start[1]),
      .rx_data   (rx_data[1]),
      .rx_valid  (rx_valid[1]),
      .rx_ready  (rx_ready[1]),
      .wr_en     (wr_en[1]),
      .wr_addr   (wr_addr[1]),
      .wr_data   (wr_data[1]),
      .core_hold (core_hold[1]),
      .done      (done[1]),
      .error     (error[1])
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      total++;
      assert (got === want) else begin
         bad++;
         $error("FAIL %s: got %h, want %h", tag, got, want);
      end
   endtask

   // Every write strobe must match the oldest expected {dut, addr, data}.
   initial forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         if (wr_en[i] === 1'b1) begin
            check($sformatf("write_expected dut%0d", i), 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
               mon_e = exp_q.pop_front();
               check("write_dut", 32'(i), 32'(mon_e[64]));
               check($sformatf("wr_addr dut%0d", i), wr_addr[i], mon_e[63:32]);
               check($sformatf("wr_data dut%0d", i), wr_data[i], mon_e[31:0]);
            end
         end
      end
   end

   // Called at a negedge; returns at the negedge after the byte transfers.
   task automatic put(input int i, input logic [7:0] b, input bit gap);
      int n;
      if (gap) begin
         rx_valid[i] = 1'b0;
         @(negedge clk);
      end
      rx_data[i]  = b;
      rx_valid[i] = 1'b1;
      n = 0;
      while (rx_ready[i] !== 1'b1 && n < 8) begin
         @(negedge clk);
         n++;
      end
      check($sformatf("rx_ready_for_byte dut%0d", i), 32'(rx_ready[i]), 32'd1);
      @(negedge clk);
      rx_valid[i] = 1'b0;
   endtask

   task automatic send_word(input int i, input logic [31:0] w, input int k, input bit gap);
      logic [31:0] base;
      logic [0:0]  idx;
      base = (i == 0) ? Base0 : Base1;
      idx  = 1'(i);
      exp_q.push_back({idx, base + 32'(4 * k), w});
      for (int b = 3; b >= 0; b--) begin
         put(i, w[8*b +: 8], gap);
         chk = chk ^ w[8*b +: 8];
      end
      check($sformatf("wr_en_after_word%0d dut%0d", k, i), 32'(wr_en[i]), 32'd1);
   endtask

   task automatic pulse_start(input int i);
      start[i] = 1'b1;
      @(negedge clk);
      start[i] = 1'b0;
      chk = 8'h00;
   endtask

   initial begin
      rst_n = 1'b0;
      for (int i = 0; i < 2; i++) begin
         start[i]    = 1'b0;
         rx_valid[i] = 1'b0;
         rx_data[i]  = 8'h00;
      end
      repeat (2) @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         check($sformatf("rst_rx_ready dut%0d", i), 32'(rx_ready[i]), 32'd0);
         check($sformatf("rst_wr_en dut%0d", i), 32'(wr_en[i]), 32'd0);
         check($sformatf("rst_wr_data dut%0d", i), wr_data[i], 32'd0);
         check($sformatf("rst_core_hold dut%0d", i), 32'(core_hold[i]), 32'd1);
         check($sformatf("rst_done dut%0d", i), 32'(done[i]), 32'd0);
         check($sformatf("rst_error dut%0d", i), 32'(error[i]), 32'd0);
      end
      check("rst_wr_addr dut0", wr_addr[0], Base0);
      check("rst_wr_addr dut1", wr_addr[1], Base1);
      rst_n = 1'b1;
      @(negedge clk);

      // Reset in the middle of the second word.
      pulse_start(0);
      put(0, 8'h00, 1'b0);
      put(0, 8'h02, 1'b0);
      send_word(0, 32'h1234_5678, 0, 1'b0);
      put(0, 8'h9A, 1'b0);
      put(0, 8'hBC, 1'b0);
      rst_n = 1'b0;
      #1;
      check("midrst_core_hold", 32'(core_hold[0]), 32'd1);
      check("midrst_rx_ready", 32'(rx_ready[0]), 32'd0);
      check("midrst_wr_addr", wr_addr[0], Base0);
      @(negedge clk);
      rst_n       = 1'b1;
      rx_valid[0] = 1'b1;
      rx_data[0]  = 8'h55;
      repeat (4) @(negedge clk);
      check("idle_rx_ready", 32'(rx_ready[0]), 32'd0);
      check("idle_core_hold", 32'(core_hold[0]), 32'd1);
      rx_valid[0] = 1'b0;

      // Good two-word frame at one byte per cycle.
      pulse_start(0);
      t0 = cyc;
      put(0, 8'h00, 1'b0);
      put(0, 8'h02, 1'b0);
      send_word(0, 32'h1234_5678, 0, 1'b0);
      send_word(0, 32'hDEAD_BEEF, 1, 1'b0);
      check("check_state_rx_ready", 32'(rx_ready[0]), 32'd1);
      check("check_state_done", 32'(done[0]), 32'd0);
      put(0, chk, 1'b0);
      check("good_done", 32'(done[0]), 32'd1);
      check("good_core_hold", 32'(core_hold[0]), 32'd0);
      check("good_error", 32'(error[0]), 32'd0);
      check("good_rx_ready", 32'(rx_ready[0]), 32'd0);
      check("good_latency", 32'(cyc - t0), 32'd11);

      // Same frame, wrong checksum.
      pulse_start(0);
      check("restart_done_clear", 32'(done[0]), 32'd0);
      check("restart_core_hold", 32'(core_hold[0]), 32'd1);
      put(0, 8'h00, 1'b0);
      put(0, 8'h02, 1'b0);
      send_word(0, 32'h1234_5678, 0, 1'b0);
      send_word(0, 32'hDEAD_BEEF, 1, 1'b0);
      put(0, chk ^ 8'h01, 1'b0);
      check("badsum_error", 32'(error[0]), 32'd1);
      check("badsum_done", 32'(done[0]), 32'd0);
      check("badsum_core_hold", 32'(core_hold[0]), 32'd1);

      // Length one past MAX_WORDS.
      pulse_start(0);
      check("restart_error_clear", 32'(error[0]), 32'd0);
      put(0, 8'h01, 1'b0);
      put(0, 8'h01, 1'b0);
      check("toolong_error", 32'(error[0]), 32'd1);
      check("toolong_rx_ready", 32'(rx_ready[0]), 32'd0);
      check("toolong_wr_en", 32'(wr_en[0]), 32'd0);

      // Empty program.
      pulse_start(0);
      put(0, 8'h00, 1'b0);
      put(0, 8'h00, 1'b0);
      check("empty_rx_ready", 32'(rx_ready[0]), 32'd1);
      check("empty_done_early", 32'(done[0]), 32'd0);
      put(0, 8'h00, 1'b0);
      check("empty_done", 32'(done[0]), 32'd1);

      // start coinciding with a LEN_LO transfer must be ignored.
      pulse_start(0);
      put(0, 8'h00, 1'b0);
      start[0] = 1'b1;
      put(0, 8'h01, 1'b0);
      start[0] = 1'b0;
      send_word(0, 32'hCAFE_F00D, 0, 1'b0);
      put(0, chk, 1'b0);
      check("start_ignored_done", 32'(done[0]), 32'd1);

      // Base near top of address space, rx_valid toggling.
      pulse_start(1);
      put(1, 8'h00, 1'b1);
      put(1, 8'h02, 1'b1);
      send_word(1, 32'h1122_3344, 0, 1'b1);
      send_word(1, 32'h5566_7788, 1, 1'b1);
      put(1, chk, 1'b1);
      check("wrap_done", 32'(done[1]), 32'd1);
      check("wrap_core_hold", 32'(core_hold[1]), 32'd0);

      repeat (3) @(negedge clk);
      check("all_writes_seen", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
